// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types
// FSM encoding, AXI response codes, helpers
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WREQ,
    S_WRESP,
    S_DONE
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way grant select
// round-robin or fixed priority, pointer starts at 1
module rr_arbiter2 #(
  parameter bit PRIO_RR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_any,
  output logic       gnt_idx
);

  logic last_q;
  logic last_d;

  // pick a winner; pointer follows every taken grant
  always_comb begin
    gnt_any = |req;
    gnt_idx = 1'b0;
    last_d  = last_q;
    case (req)
      2'b11:   gnt_idx = PRIO_RR ? ~last_q : 1'b0;
      2'b10:   gnt_idx = 1'b1;
      default: gnt_idx = 1'b0;
    endcase
    if (take) last_d = gnt_idx;
  end

  // last-grant pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= 1'b1;
    else      last_q <= last_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: IFU/LSU to AXI-lite bridge
// one transaction in flight, response held until taken
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int PRIO_RR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_wen,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic arb_any;
  logic arb_idx;
  logic take;
  logic aw_fin;
  logic w_fin;

  assign take = rst & arb_any & (state_q == S_IDLE);

  rr_arbiter2 #(
    .PRIO_RR (PRIO_RR != 0)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .take    (take),
    .gnt_any (arb_any),
    .gnt_idx (arb_idx)
  );

  // next state, latched request and bus outputs
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    aw_fin     = 1'b0;
    w_fin      = 1'b0;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    m_araddr   = addr_q;
    m_awaddr   = addr_q;
    m_wdata    = wdata_q;
    m_wstrb    = wstrb_q;
    resp_rdata = rdata_q;
    resp_err   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (take) begin
          req_ready = onehot2(arb_idx);
          gnt_d     = arb_idx;
          addr_d    = arb_idx ? req_addr[63:32] : req_addr[31:0];
          wen_d     = arb_idx ? req_wen[1] : req_wen[0];
          wdata_d   = arb_idx ? req_wdata[63:32] : req_wdata[31:0];
          wstrb_d   = arb_idx ? req_wstrb[7:4] : req_wstrb[3:0];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = wen_d ? S_WREQ : S_RADDR;
        end
      end
      S_RADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = S_RDATA;
      end
      S_RDATA: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          rdata_d = m_rdata;
          err_d   = RESP_OKAY[1];
          state_d = S_DONE;
        end
      end
      S_WREQ: begin
        m_awvalid = ~aw_done_q;
        m_wvalid  = ~w_done_q;
        aw_fin    = aw_done_q | m_awready;
        w_fin     = w_done_q | m_wready;
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) state_d = S_WRESP;
      end
      S_WRESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          err_d   = (m_bresp & RESP_SLVERR) != RESP_OKAY;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        resp_valid = onehot2(gnt_q);
        if (resp_ready[gnt_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and latched request registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

endmodule
